// File: rtl/program_sequencer.sv
`timescale 1ns/1ps
// Programming-run sequencer: starts program_decoder block by block, forwards data
// blocks to the NVM write engine and reports progress plus a sticky error code.
module program_sequencer #(
    parameter int DATA_BLOCK_MAX_SIZE = 64,
    parameter int MAX_BLOCKS          = 1024,
    parameter int BLK_CNT_BITS        = $clog2(MAX_BLOCKS + 1),
    parameter int TIMEOUT_CYCLES      = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [2:0]              err_code,
    output logic [BLK_CNT_BITS-1:0] blocks_written,
    output logic                    dec_start,
    input  logic                    dec_ready,
    input  logic                    dec_done,
    input  logic [7:0]              dec_block_length,
    input  logic [15:0]             dec_block_address,
    input  logic [7:0]              dec_block_type,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [15:0]             wr_address,
    output logic [7:0]              wr_length,
    input  logic                    wr_done,
    input  logic                    wr_error
);
    localparam int TMR_BITS = $clog2(TIMEOUT_CYCLES + 1);
    // One extra bit so the decoded-block count can reach MAX_BLOCKS+1 for any MAX_BLOCKS.
    localparam int BLK_BITS = BLK_CNT_BITS + 1;

    localparam logic [TMR_BITS-1:0]     TMR_LAST  = TMR_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [BLK_BITS-1:0]     BLK_LIMIT = BLK_BITS'(MAX_BLOCKS);
    localparam logic [7:0]              LEN_LIMIT = 8'(DATA_BLOCK_MAX_SIZE);
    localparam logic [BLK_CNT_BITS-1:0] BW_SAT    = '1;

    localparam logic [2:0] ERR_WRITER  = 3'd1;
    localparam logic [2:0] ERR_TOO_LONG = 3'd2;
    localparam logic [2:0] ERR_TOO_MANY = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_ABORTED = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_DEC_START, S_DEC_ACK, S_DEC_WAIT, S_DISPATCH,
        S_WR_REQ, S_WR_WAIT, S_DONE, S_ERROR
    } state_t;

    state_t                    state_reg, state_next;
    logic [2:0]                fail_code;
    logic [TMR_BITS-1:0]       timer_reg;
    logic [BLK_BITS-1:0]       blk_cnt_reg;
    logic [7:0]                type_reg;
    logic [15:0]               wr_address_reg;
    logic [7:0]                wr_length_reg;
    logic                      done_reg, error_reg;
    logic [2:0]                err_code_reg;
    logic [BLK_CNT_BITS-1:0]   bw_reg;
    logic                      dec_start_reg;
    logic                      pend_done_reg, pend_err_reg;
    logic                      busy_w, timed_state, timed_out;

    assign busy_w      = !(state_reg inside {S_IDLE, S_DONE, S_ERROR});
    assign timed_state = state_reg inside {S_DEC_ACK, S_DEC_WAIT, S_WR_REQ, S_WR_WAIT};
    assign timed_out   = timer_reg == TMR_LAST;

    always_comb begin
        state_next = state_reg;
        fail_code  = 3'd0;
        case (state_reg)
            S_IDLE:      if (start) state_next = S_DEC_START;
            S_DEC_START: if (dec_ready) state_next = S_DEC_ACK;
            S_DEC_ACK: begin
                if (!dec_ready) state_next = S_DEC_WAIT;
                else if (timed_out) begin state_next = S_ERROR; fail_code = ERR_TIMEOUT; end
            end
            S_DEC_WAIT: begin
                if (dec_ready && dec_done) state_next = S_DISPATCH;
                else if (timed_out) begin state_next = S_ERROR; fail_code = ERR_TIMEOUT; end
            end
            S_DISPATCH: begin
                if (blk_cnt_reg > BLK_LIMIT) begin
                    state_next = S_ERROR;
                    fail_code  = ERR_TOO_MANY;
                end else if (type_reg == 8'h01) begin
                    state_next = S_DONE;
                end else if (type_reg == 8'h00) begin
                    if (wr_length_reg > LEN_LIMIT) begin
                        state_next = S_ERROR;
                        fail_code  = ERR_TOO_LONG;
                    end else if (wr_length_reg == 8'd0) begin
                        state_next = S_DEC_START;
                    end else begin
                        state_next = S_WR_REQ;
                    end
                end else begin
                    state_next = S_DEC_START;
                end
            end
            S_WR_REQ: begin
                if (wr_ready) state_next = S_WR_WAIT;
                else if (timed_out) begin state_next = S_ERROR; fail_code = ERR_TIMEOUT; end
            end
            S_WR_WAIT: begin
                // A completion seen during the accept cycle is held in pend_*_reg.
                if (wr_error || pend_err_reg) begin
                    state_next = S_ERROR;
                    fail_code  = ERR_WRITER;
                end else if (wr_done || pend_done_reg) begin
                    state_next = S_DEC_START;
                end else if (timed_out) begin
                    state_next = S_ERROR;
                    fail_code  = ERR_TIMEOUT;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERROR: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (busy_w && abort) begin
            state_next = S_ERROR;
            fail_code  = ERR_ABORTED;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            timer_reg      <= '0;
            blk_cnt_reg    <= '0;
            type_reg       <= '0;
            wr_address_reg <= '0;
            wr_length_reg  <= '0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            err_code_reg   <= '0;
            bw_reg         <= '0;
            dec_start_reg  <= 1'b0;
            pend_done_reg  <= 1'b0;
            pend_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (state_next != state_reg)
                timer_reg <= '0;
            else if (timed_state)
                timer_reg <= timer_reg + 1'b1;

            dec_start_reg <= (state_reg == S_DEC_START) && (state_next == S_DEC_ACK);

            if (state_reg == S_IDLE && start) begin
                done_reg     <= 1'b0;
                error_reg    <= 1'b0;
                err_code_reg <= '0;
                bw_reg       <= '0;
                blk_cnt_reg  <= '0;
            end

            if (state_reg == S_DEC_WAIT && state_next == S_DISPATCH) begin
                wr_address_reg <= dec_block_address;
                wr_length_reg  <= dec_block_length;
                type_reg       <= dec_block_type;
                blk_cnt_reg    <= blk_cnt_reg + 1'b1;
            end

            if (state_reg == S_WR_REQ && state_next == S_WR_WAIT) begin
                pend_done_reg <= wr_done;
                pend_err_reg  <= wr_error;
            end else if (state_next != S_WR_WAIT) begin
                pend_done_reg <= 1'b0;
                pend_err_reg  <= 1'b0;
            end

            if (state_reg == S_WR_WAIT && state_next == S_DEC_START && bw_reg != BW_SAT)
                bw_reg <= bw_reg + 1'b1;

            if (state_next == S_DONE)
                done_reg <= 1'b1;

            if (state_next == S_ERROR) begin
                error_reg    <= 1'b1;
                err_code_reg <= fail_code;
            end
        end
    end

    assign busy           = busy_w;
    assign done           = done_reg;
    assign error          = error_reg;
    assign err_code       = err_code_reg;
    assign blocks_written = bw_reg;
    assign dec_start      = dec_start_reg;
    assign wr_valid       = state_reg == S_WR_REQ;
    assign wr_address     = wr_address_reg;
    assign wr_length      = wr_length_reg;
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Top-level sequencer for flash programming; sits between the host/button start logic, program_decoder and the UPDI NVM write engine.
- Repeatedly starts program_decoder and classifies each decoded block:
  - data blocks go to the write engine over a valid/ready + done handshake;
  - an EOF block ends the run.
- Reports progress, completion and a sticky error code.

Parameters:
- DATA_BLOCK_MAX_SIZE, 64, max data bytes per block; a longer block is an error.
- MAX_BLOCKS, 1024, max decoded blocks per run, EOF included; exceeding it is an error.
- BLK_CNT_BITS, $clog2(MAX_BLOCKS+1), width of the block counters.
- TIMEOUT_CYCLES, 1000000, max cycles spent waiting on the decoder or the writer per step.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- start  input  1  begin a programming run (sampled in IDLE)
- abort  input  1  cancel the run from any busy state
- busy  output  1  run in progress
- done  output  1  run completed successfully; sticky until next start
- error  output  1  run failed; sticky until next start
- err_code  output  3  0 none, 1 writer error, 2 block too long, 3 too many blocks, 4 timeout, 5 aborted
- blocks_written  output  BLK_CNT_BITS  data blocks accepted by the writer this run
- dec_start  output  1  start pulse to program_decoder
- dec_ready  input  1  decoder ready
- dec_done  input  1  decoder block done
- dec_block_length  input  8  decoded length
- dec_block_address  input  16  decoded address
- dec_block_type  input  8  decoded type
- wr_valid  output  1  write request valid
- wr_ready  input  1  writer accepts request
- wr_address  output  16  flash address of block
- wr_length  output  8  byte count of block
- wr_done  input  1  one-cycle pulse: write finished
- wr_error  input  1  one-cycle pulse: write failed (may coincide with wr_done; error wins)

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0, including err_code, blocks_written and the internal block/timeout counters.
- Timeout counter:
  - clears on every state change;
  - increments in DEC_ACK, DEC_WAIT, WR_REQ and WR_WAIT;
  - reaching TIMEOUT_CYCLES in any of these states gives ERROR with err_code=4.
- States and transitions:
  - IDLE:
    - busy=0.
    - On start: clear done, error, err_code, blocks_written and the block counter; busy=1; go to DEC_START.
  - DEC_START:
    - Wait for dec_ready=1, then assert dec_start for exactly one cycle and go to DEC_ACK.
  - DEC_ACK:
    - Wait for dec_ready=0, which confirms the decoder left idle; go to DEC_WAIT.
  - DEC_WAIT:
    - Wait for dec_ready=1 and dec_done=1.
    - Latch length, address and type into wr_length and wr_address, plus an internal type register.
    - Increment the block counter; go to DISPATCH.
  - DISPATCH (one cycle):
    - Checks are evaluated in this order.
    - Block counter > MAX_BLOCKS: ERROR, code 3.
    - type 0x01: DONE.
    - type 0x00 and length > DATA_BLOCK_MAX_SIZE: ERROR, code 2.
    - type 0x00 and length = 0: DEC_START; no write is issued.
    - type 0x00 otherwise: WR_REQ.
    - any other type: ignored, go to DEC_START.
  - WR_REQ:
    - wr_valid=1, with wr_address and wr_length held stable.
    - On wr_ready=1: wr_valid drops the next cycle; go to WR_WAIT.
  - WR_WAIT:
    - On wr_error: ERROR, code 1.
    - Else on wr_done: blocks_written+1, then DEC_START.
    - wr_done or wr_error arriving in the same cycle as the wr_ready accept is registered and honoured.
  - DONE: done=1, busy=0; go to IDLE.
  - ERROR: error=1, busy=0, err_code set; go to IDLE.
- abort:
  - In any busy state, abort=1 gives ERROR with code 5 on the next edge.
  - abort takes priority over every other transition in that cycle.
  - wr_valid drops at that same edge.
  - abort in IDLE is ignored.
- start while busy: ignored.
- blocks_written saturates at all-ones.
- Reset mid-run returns to IDLE immediately. The decoder and writer are not notified; their own resets handle that.

Test Plan:
- Two data blocks (len 16 @0x0000, len 8 @0x0010) then EOF -> two wr_valid requests with matching address/length; done=1, blocks_written=2, error=0.
- Data block len 0, type 0x02 block, then EOF -> no wr_valid at all; done=1, blocks_written=0.
- Data block len 65 -> no write; error=1, err_code=2, busy=0.
- Writer returns wr_error on the first block -> error=1, err_code=1, blocks_written=0; a second start runs cleanly after a good program.
- Writer holds wr_ready=0 (TIMEOUT_CYCLES=100) -> error at cycle 100 of WR_REQ, err_code=4. With MAX_BLOCKS=2 and 3 data blocks -> err_code=3.
- abort asserted during WR_WAIT -> next cycle error=1, err_code=5, wr_valid=0. rst pulsed low mid-run -> all outputs 0 asynchronously.
